// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
//
// Purpose:
//   Instruction fetch stage with a one-entry output buffer. It holds a
//   word-addressed program counter, requests instructions from instruction
//   memory, buffers each returned word together with its address, and hands
//   it to a consumer that can stall. Jumps and taken branches redirect the
//   PC and flush the buffer. Every instruction the consumer accepts is
//   counted in fetch_count.
//
// Ports:
//   clock          in   single clock, all state changes on rising edge
//   reset          in   synchronous active-high reset
//   stall          in   consumer is not accepting the buffered instruction
//   branch_taken   in   redirect request to branch_target
//   branch_target  in   [31:0] word address of branch destination
//   jump           in   redirect request to jump_target (beats branch)
//   jump_target    in   [31:0] word address of jump destination
//   imem_ready     in   imem_data is valid for imem_addr this cycle
//   imem_data      in   [31:0] instruction word from memory
//   imem_req       out  fetch request to instruction memory (combinational)
//   imem_addr      out  [31:0] word address being fetched, always the PC
//   instr_valid    out  instr / instr_pc hold a valid instruction
//   instr          out  [31:0] buffered instruction word
//   instr_pc       out  [31:0] word address of the buffered instruction
//   fetch_count    out  [31:0] instructions accepted since reset (wraps)
// ---------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_count
);

    // FETCH: buffer free or draining. HOLD: buffer full and consumer stalled.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] instr_pc_nxt;
    logic [31:0] count_nxt;
    logic        req;

    logic        redirect;
    logic [31:0] target;
    logic        accept;

    // Jump has priority over a taken branch when both arrive together.
    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_target : branch_target;
    assign accept    = instr_valid & ~stall;
    assign imem_addr = pc;
    assign imem_req  = req;

    // State register. Reset wins over every other input and drops any
    // buffered instruction without counting it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= valid_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            fetch_count <= count_nxt;
        end
    end

    // Next-state and request logic. Everything holds by default; the
    // accept counter is independent of the FSM, so an instruction taken in
    // the same cycle as a redirect is still counted.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        valid_nxt    = instr_valid;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        count_nxt    = accept ? fetch_count + 32'd1 : fetch_count;
        req          = 1'b0;

        case (state)
            FETCH: begin
                // A new word may land only if the buffer is empty or being
                // drained this very cycle, which gives back-to-back delivery.
                req = ~redirect & (~instr_valid | ~stall);
                if (redirect) begin
                    pc_nxt    = target;
                    valid_nxt = 1'b0;
                end else if (req && imem_ready) begin
                    instr_nxt    = imem_data;
                    instr_pc_nxt = pc;
                    pc_nxt       = pc + 32'd1;
                    valid_nxt    = 1'b1;
                end else if (accept) begin
                    valid_nxt = 1'b0;
                end else if (instr_valid && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // No fetching while held; leaving HOLD costs one idle
                // request cycle before fetching resumes.
                if (redirect) begin
                    pc_nxt    = target;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
//
// Purpose:
//   Self-checking bench for pc_fetch. Directed scenarios check the reset
//   state, sequential fetch, stall/hold, branch, jump priority, reset while
//   held and PC wrap-around (on a second instance with RESET_PC at the top
//   of the address space). A randomized run compares the main instance
//   against a cycle-level reference model of the fetch buffer.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_ready;
    logic [31:0] imem_data;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] fetch_count;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic [31:0] w_count;

    int checks;
    int errors;

    // Reference model of the fetch stage
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_count;
    logic        m_hold;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .fetch_count(fetch_count)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .imem_req(w_req), .imem_addr(w_addr),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_ipc),
        .fetch_count(w_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply one cycle's worth of inputs and let combinational outputs settle.
    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic rdy, input logic [31:0] d);
        stall         = s;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        imem_ready    = rdy;
        imem_data     = d;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    // Fetch n consecutive words with no stalls; data word = 0x1000_0000 + address.
    task automatic fetch_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1000_0000 + imem_addr);
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (instr_valid !== 1'b0 || fetch_count !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: valid=%b count=%0d instr=%h ipc=%h, expected 0 0 0 0",
                     instr_valid, fetch_count, instr, instr_pc);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hA000_0000 + k);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== k) begin
                errors++;
                $display("[TB] FAIL seq_addr[%0d]: req=%b addr=%h, expected 1 %h", k, imem_req, imem_addr, k);
            end
            if (k >= 1) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== k - 1 || instr !== 32'hA000_0000 + k - 1) begin
                    errors++;
                    $display("[TB] FAIL seq_buf[%0d]: valid=%b ipc=%h instr=%h, expected 1 %h %h",
                             k, instr_valid, instr_pc, instr, k - 1, 32'hA000_0000 + k - 1);
                end
            end
            tick();
        end
        checks++;
        if (fetch_count !== 32'd3 || instr_pc !== 32'd3) begin
            errors++;
            $display("[TB] FAIL seq_count: count=%0d ipc=%h, expected 3 00000003", fetch_count, instr_pc);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        fetch_n(6);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000 + k);
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'd5 ||
                instr !== 32'h1000_0005 || imem_addr !== 32'd6 || fetch_count !== 32'd5) begin
                errors++;
                $display("[TB] FAIL stall[%0d]: req=%b valid=%b ipc=%h instr=%h addr=%h count=%0d, expected 0 1 5 10000005 6 5",
                         k, imem_req, instr_valid, instr_pc, instr, imem_addr, fetch_count);
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAD0_00FF);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release_req: req=%b, expected 0", imem_req);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1000_0006);
        checks++;
        if (instr_valid !== 1'b0 || fetch_count !== 32'd6 || imem_req !== 1'b1 || imem_addr !== 32'd6) begin
            errors++;
            $display("[TB] FAIL hold_accept: valid=%b count=%0d req=%b addr=%h, expected 0 6 1 6",
                     instr_valid, fetch_count, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'd6 || instr !== 32'h1000_0006) begin
            errors++;
            $display("[TB] FAIL resume: valid=%b ipc=%h instr=%h, expected 1 6 10000006", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_branch();
        do_reset();
        fetch_n(7);
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd7) begin
            errors++;
            $display("[TB] FAIL branch_req: req=%b addr=%h, expected 0 7", imem_req, imem_addr);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h40 || fetch_count !== 32'd7 || imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_redirect: valid=%b addr=%h count=%0d req=%b, expected 0 40 7 1",
                     instr_valid, imem_addr, fetch_count, imem_req);
        end
    endtask

    task automatic test_jump_priority();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jump_priority: addr=%h valid=%b, expected 100 0", imem_addr, instr_valid);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        fetch_n(10);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        checks++;
        if (fetch_count !== 32'd9 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset_hold: count=%0d valid=%b req=%b, expected 9 1 0",
                     fetch_count, instr_valid, imem_req);
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (instr_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_hold: valid=%b count=%0d addr=%h req=%b, expected 0 0 0 1",
                     instr_valid, fetch_count, imem_addr, imem_req);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL wrap_start: req=%b addr=%h, expected 1 ffffffff", w_req, w_addr);
        end
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (w_valid !== 1'b1 || w_ipc !== 32'hFFFF_FFFF || w_instr !== 32'hCAFE_F00D ||
            w_addr !== 32'h0 || w_count !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_next: valid=%b ipc=%h instr=%h addr=%h count=%0d, expected 1 ffffffff cafef00d 0 0",
                     w_valid, w_ipc, w_instr, w_addr, w_count);
        end
    endtask

    // One clock of the reference model, from the stage's behavioural rules.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        logic        acc;
        logic        can_fetch;
        redir     = jump | branch_taken;
        tgt       = jump ? jump_target : branch_target;
        acc       = m_valid && !stall;
        can_fetch = !m_hold && !redir && (!m_valid || !stall);
        if (reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_count = 32'h0; m_hold = 1'b0;
        end else begin
            if (acc) m_count = m_count + 1;
            if (redir) begin
                m_pc = tgt; m_valid = 1'b0; m_hold = 1'b0;
            end else if (m_hold) begin
                if (!stall) begin m_valid = 1'b0; m_hold = 1'b0; end
            end else if (can_fetch && imem_ready) begin
                m_instr = imem_data; m_ipc = m_pc; m_pc = m_pc + 1; m_valid = 1'b1;
            end else if (acc) begin
                m_valid = 1'b0;
            end else if (m_valid && stall) begin
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        logic exp_req;
        do_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_count = 32'h0; m_hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom(),
                  $urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 9) < 7, $urandom());
            exp_req = !m_hold && !(jump | branch_taken) && (!m_valid || !stall);
            checks++;
            if (imem_req !== exp_req || imem_addr !== m_pc || instr_valid !== m_valid ||
                instr !== m_instr || instr_pc !== m_ipc || fetch_count !== m_count) begin
                errors++;
                $display("[TB] FAIL random[%0d]: req=%b addr=%h valid=%b instr=%h ipc=%h count=%0d, expected %b %h %b %h %h %0d",
                         n, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_count,
                         exp_req, m_pc, m_valid, m_instr, m_ipc, m_count);
            end
            model_step();
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch();
        test_jump_priority();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address loaded into the PC on reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-004 stall  input  1  consumer not accepting; instruction held while instr_valid=1 and stall=1.
REQ-005 branch_taken  input  1  redirect request to branch_target.
REQ-006 branch_target  input  32  word address of branch destination.
REQ-007 jump  input  1  redirect request to jump_target; priority over branch_taken.
REQ-008 jump_target  input  32  word address of jump destination.
REQ-009 imem_ready  input  1  instruction memory returns imem_data for imem_addr this cycle.
REQ-010 imem_data  input  32  instruction word from memory.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  32  word address being fetched; equals pc.
REQ-013 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-014 instr  output  32  buffered instruction word.
REQ-015 instr_pc  output  32  word address of buffered instruction.
REQ-016 fetch_count  output  32  number of instructions delivered (accepted) since reset.

Function
REQ-017 Internal pc register SHALL be 32 bits, word-addressed; sequential next PC = pc + 1, modulo 2^32 (32'hFFFF_FFFF -> 32'h0000_0000, no flag).
REQ-018 FSM SHALL have two states: FETCH (buffer free or draining) and HOLD (buffer full, stall=1).
REQ-019 redirect = jump | branch_taken; target = jump ? jump_target : branch_target.
REQ-020 imem_req SHALL be combinational: 1 iff state=FETCH, redirect=0, and (instr_valid=0 or stall=0); imem_addr = pc at all times.
REQ-021 Accept = instr_valid & ~stall; on accept fetch_count SHALL increment by 1 (wraps at 2^32).
REQ-022 In FETCH with redirect=1: pc <= target, instr_valid <= 0, any imem_ready/imem_data that cycle discarded, state stays FETCH; latency redirect -> imem_addr=target is 1 cycle.
REQ-023 In FETCH with redirect=0, imem_req=1, imem_ready=1: instr <= imem_data, instr_pc <= pc, pc <= pc+1, instr_valid <= 1; data visible the next cycle (1-cycle latency).
REQ-024 In FETCH with redirect=0, imem_ready=0: if accept, instr_valid <= 0; else instr_valid unchanged; if instr_valid=1 and stall=1, state <= HOLD.
REQ-025 In HOLD: imem_req=0; instr, instr_pc, instr_valid, pc stable; imem_ready ignored.
REQ-026 HOLD -> FETCH when stall=0 (instruction accepted that cycle, instr_valid <= 0) or redirect=1 (apply REQ-022, held instruction flushed, not counted).
REQ-027 Simultaneous accept and new fetch (instr_valid=1, stall=0, imem_ready=1) SHALL replace buffer back-to-back; sustained throughput 1 instruction/cycle.
REQ-028 Simultaneous redirect and accept: accept counted, buffer flushed, pc <= target.
REQ-029 jump=1 and branch_taken=1 in same cycle: jump_target SHALL win.

Reset
REQ-030 While reset=1 at a rising edge: pc <= RESET_PC, state <= FETCH, instr_valid <= 0, instr <= 0, instr_pc <= 0, fetch_count <= 0; reset overrides all other inputs.
REQ-031 Reset mid-operation (HOLD or pending fetch) SHALL drop buffered instruction with no count; first imem_req=1 with imem_addr=RESET_PC the cycle after reset deasserts.

Verification
REQ-032 Reset, imem_ready=1 every cycle, stall=0 for 4 cycles -> imem_addr 0,1,2,3; instr_pc 0,1,2 follow one cycle later; fetch_count=3 after cycle 4.
REQ-033 Buffer valid at instr_pc=5, stall=1 for 3 cycles -> imem_req=0, instr/instr_pc/pc (=6) unchanged; stall=0 -> accept, fetch resumes at 6.
REQ-034 branch_taken=1, branch_target=0x40 while imem_ready=1 at pc=7 -> imem_data discarded, instr_valid=0 next cycle, imem_addr=0x40.
REQ-035 jump=1 (jump_target=0x100) and branch_taken=1 (branch_target=0x200) same cycle -> imem_addr=0x100 next cycle.
REQ-036 RESET_PC=32'hFFFF_FFFF, one fetch -> instr_pc=0xFFFF_FFFF, next imem_addr=0x0000_0000.
REQ-037 reset=1 asserted while in HOLD with fetch_count=9 -> next cycle instr_valid=0, fetch_count=0, imem_addr=RESET_PC.
